wb_rr_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 40 ++++
 rtl/wb_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/wb_rr_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared definitions for the round-robin Wishbone arbiter:
//   - arb_state_e     : arbiter state encoding (IDLE / OWNED / ABORT)
//   - DEFAULT_TIMEOUT : default watchdog length in clock cycles
//   - bus_slice()     : extracts field <idx> of width <w> from a packed
//                       per-master bus (fields up to SLICE_MAX_W bits wide,
//                       buses up to SLICE_BUS_W bits wide)
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Field and bus limits cover 8 masters with 64-bit fields.
    localparam int SLICE_MAX_W = 64;
    localparam int SLICE_BUS_W = 8 * SLICE_MAX_W;

    function automatic logic [SLICE_MAX_W-1:0] bus_slice(
        input logic [SLICE_BUS_W-1:0] bus,
        input int                     idx,
        input int                     w
    );
        logic [SLICE_BUS_W-1:0] shifted;
        logic [SLICE_MAX_W-1:0] mask;
        shifted = bus >> (idx * w);
        if (w >= SLICE_MAX_W) begin
            mask = '1;
        end else begin
            mask = (SLICE_MAX_W'(1) << w) - SLICE_MAX_W'(1);
        end
        return shifted[SLICE_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Scans ptr+1, ptr+2, ... modulo NUM_M and
// selects the first set bit of req.
// Ports:
//   req  in  NUM_M  request vector
//   ptr  in  PTR_W  index of the most recent winner
//   gnt  out NUM_M  one-hot selection (zero when nothing requests)
//   vld  out 1      at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_M = 4,
    parameter int PTR_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NUM_M-1:0] gnt,
    output logic             vld
);

    logic [NUM_M-1:0] req_rot;
    logic [NUM_M-1:0] first_rot;
    int               shift;

    // Rotate the requests so the highest-priority candidate (ptr+1) sits at
    // bit 0, take the lowest set bit, then rotate the choice back.
    always_comb begin
        shift     = int'(ptr) + 1;
        req_rot   = NUM_M'({req, req} >> shift);
        first_rot = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                first_rot    = '0;
                first_rot[i] = 1'b1;
            end
        end
        gnt = NUM_M'(({first_rot, first_rot} << shift) >> NUM_M);
        vld = |req;
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Round-robin Wishbone arbiter sharing one slave port among NUM_M masters.
// A grant is registered and held for the owner's whole cyc; a per-transfer
// watchdog aborts a stalled slave by returning err to the owner.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i   per-master controls (NUM_M)
//   m_adr_i/m_dat_i/m_sel_i  packed per-master address / data / byte selects
//   m_dat_o                  shared read data (= s_dat_i)
//   m_ack_o/m_err_o          per-master ack / err, only the owner's bit moves
//   s_*_o                    slave-side request, muxed from the owner
//   s_dat_i/s_ack_i/s_err_i  slave-side response
//   gnt_o                    one-hot registered grant
//   busy_o                   arbiter not idle
//   timeout_o                one-cycle pulse when the watchdog aborts
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           m_cyc_i,
    input  logic [NUM_M-1:0]           m_stb_i,
    input  logic [NUM_M-1:0]           m_we_i,
    input  logic [NUM_M*ADR_W-1:0]     m_adr_i,
    input  logic [NUM_M*DAT_W-1:0]     m_dat_i,
    input  logic [NUM_M*DAT_W/8-1:0]   m_sel_i,
    output logic [DAT_W-1:0]           m_dat_o,
    output logic [NUM_M-1:0]           m_ack_o,
    output logic [NUM_M-1:0]           m_err_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [ADR_W-1:0]           s_adr_o,
    output logic [DAT_W-1:0]           s_dat_o,
    output logic [DAT_W/8-1:0]         s_sel_o,
    input  logic [DAT_W-1:0]           s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    output logic [NUM_M-1:0]           gnt_o,
    output logic                       busy_o,
    output logic                       timeout_o
);

    localparam int SEL_W = DAT_W / 8;
    localparam int PTR_W = $clog2(NUM_M);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    arb_state_e       state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;   // first cycle of ABORT

    logic [NUM_M-1:0] pick_gnt;
    logic             pick_vld;
    logic [PTR_W-1:0] pick_idx;

    logic             own_cyc, own_stb, own_we;
    logic [ADR_W-1:0] own_adr;
    logic [DAT_W-1:0] own_dat;
    logic [SEL_W-1:0] own_sel;
    logic             slv_done;
    logic             wd_expire;

    rr_pick #(
        .NUM_M (NUM_M),
        .PTR_W (PTR_W)
    ) u_pick (
        .req (m_cyc_i),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_M; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // While a master holds the bus, ptr_q is its index, so it doubles as
    // the mux select for the owner's signals.
    always_comb begin
        own_cyc = m_cyc_i[ptr_q];
        own_stb = m_stb_i[ptr_q];
        own_we  = m_we_i[ptr_q];
        own_adr = ADR_W'(bus_slice(SLICE_BUS_W'(m_adr_i), int'(ptr_q), ADR_W));
        own_dat = DAT_W'(bus_slice(SLICE_BUS_W'(m_dat_i), int'(ptr_q), DAT_W));
        own_sel = SEL_W'(bus_slice(SLICE_BUS_W'(m_sel_i), int'(ptr_q), SEL_W));
    end

    assign slv_done  = s_ack_i | s_err_i;
    // A response in the expiry cycle wins over the abort.
    assign wd_expire = (TIMEOUT > 0) && (state_q == OWNED) && own_cyc && own_stb &&
                       !slv_done && (cnt_q == CNT_LAST);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_W'(NUM_M - 1);
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_vld) begin
                    state_d = OWNED;
                    gnt_d   = pick_gnt;
                    ptr_d   = pick_idx;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else if (wd_expire) begin
                    state_d = ABORT;
                    first_d = 1'b1;
                end else if (own_stb && !slv_done && (cnt_q != CNT_MAX)) begin
                    // Saturates; only counts strobed, unanswered cycles.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ABORT: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        if (slv_done) begin
            cnt_d = '0;
        end
    end

    // Output logic
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        timeout_o = 1'b0;
        m_dat_o   = s_dat_i;
        gnt_o     = gnt_q;
        busy_o    = (state_q != IDLE);
        case (state_q)
            OWNED: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                s_sel_o = own_sel;
                m_ack_o = s_ack_i ? gnt_q : '0;
                m_err_o = s_err_i ? gnt_q : '0;
            end
            ABORT: begin
                // Bus request withdrawn; the owner sees a single err.
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_dat_o = own_dat;
                s_sel_o = own_sel;
                if (first_q) begin
                    m_err_o   = gnt_q;
                    timeout_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int PW = 2;
    localparam int T16 = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [N*AW-1:0] m_adr_i = '0;
    logic [N*DW-1:0] m_dat_i = '0;
    logic [N*SW-1:0] m_sel_i = '0;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0, s_err_i = 1'b0;

    logic [DW-1:0] m_dat_o,  m_dat_8;
    logic [N-1:0]  m_ack_o,  m_ack_8, m_err_o, m_err_8, gnt_o, gnt_8;
    logic          s_cyc_o,  s_cyc_8, s_stb_o, s_stb_8, s_we_o, s_we_8;
    logic [AW-1:0] s_adr_o,  s_adr_8;
    logic [DW-1:0] s_dat_o,  s_dat_8;
    logic [SW-1:0] s_sel_o,  s_sel_8;
    logic          busy_o,   busy_8, timeout_o, timeout_8;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] gseq [0:31];

    always #5 clk = ~clk;

    wb_rr_arbiter #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(T16)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    wb_rr_arbiter #(.NUM_M(N), .ADR_W(AW), .DAT_W(DW), .TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_8), .m_ack_o(m_ack_8), .m_err_o(m_err_8),
        .s_cyc_o(s_cyc_8), .s_stb_o(s_stb_8), .s_we_o(s_we_8),
        .s_adr_o(s_adr_8), .s_dat_o(s_dat_8), .s_sel_o(s_sel_8),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_8), .busy_o(busy_8), .timeout_o(timeout_8)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic idle_inputs();
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Each master in mask requests until it is acked while holding cyc,
    // drops cyc for one cycle, then requests again. Slave always acks.
    task automatic run_rr(input logic [N-1:0] mask, input int ncyc);
        logic [N-1:0] acked;
        acked = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m_cyc_i = mask & ~acked;
            m_stb_i = m_cyc_i;
            s_ack_i = 1'b1;
            #1;
            gseq[c] = gnt_o;
            acked = m_ack_o & m_cyc_i;
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
    endtask

    typedef struct packed {
        logic [N-1:0]  cyc;
        logic [N-1:0]  stb;
        logic          ack;
        logic          err;
        logic [DW-1:0] dat;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_ack;
        logic [N-1:0]  e_err;
        logic          e_scyc;
        logic          e_sstb;
    } vec_t;

    vec_t tbl [0:6];

    // Reference model state
    int   mo_owner, mo_ptr, mo_stall;
    logic mo_abort, mo_just;

    initial begin
        logic [N-1:0] cyc_v, stb_v, e_gnt, e_ack, e_err;
        logic [N-1:0] g_exp [0:11];
        logic [N-1:0] r_exp [0:4];
        logic         e_scyc, e_sstb, e_busy, e_tmo, e_we, dead;
        logic [AW-1:0] e_adr;

        tbl[0] = '{4'b1111, 4'b0100, 1'b1, 1'b0, 32'hA1A1_0001, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1};
        tbl[1] = '{4'b1111, 4'b0000, 1'b0, 1'b0, 32'hB2B2_0002, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0};
        tbl[2] = '{4'b1111, 4'b1011, 1'b1, 1'b0, 32'hC3C3_0003, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0};
        tbl[3] = '{4'b1111, 4'b0100, 1'b0, 1'b1, 32'hD4D4_0004, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1};
        tbl[4] = '{4'b1011, 4'b1011, 1'b0, 1'b0, 32'hE5E5_0005, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[5] = '{4'b1011, 4'b1011, 1'b0, 1'b0, 32'hF6F6_0006, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[6] = '{4'b1011, 4'b1011, 1'b0, 1'b0, 32'h0707_0007, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b1};

        // Reset values
        do_reset();
        #1;
        check("rst_gnt", gnt_o, '0);
        check("rst_ctl", {s_cyc_o, s_stb_o, s_we_o, busy_o, timeout_o}, '0);
        check("rst_resp", {m_ack_o, m_err_o}, '0);
        check("rst_sbus", {s_adr_o, s_dat_o, s_sel_o}, '0);

        // Single master read
        do_reset();
        @(negedge clk);
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        m_adr_i[0 +: AW] = 32'h2000_0000;
        #1;
        check("single_req_cycle_gnt", {busy_o, gnt_o}, '0);
        @(negedge clk); #1;
        check("single_gnt", gnt_o, 4'b0001);
        check("single_sctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b110);
        check("single_adr", s_adr_o, 32'h2000_0000);
        check("single_noack1", m_ack_o, '0);
        @(negedge clk); #1;
        check("single_noack2", m_ack_o, '0);
        @(negedge clk);
        s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        #1;
        check("single_ack", m_ack_o, 4'b0001);
        check("single_dat", m_dat_o, 32'hCAFE_F00D);
        @(negedge clk);
        idle_inputs();
        #1;
        check("single_release_still_owned", {busy_o, s_cyc_o}, 2'b10);
        @(negedge clk); #1;
        check("single_idle", {busy_o, gnt_o}, '0);

        // Fairness between masters 0 and 1
        do_reset();
        run_rr(4'b0011, 12);
        g_exp = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010,
                  4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010};
        for (int c = 0; c < 12; c++) check($sformatf("fair_gnt_c%0d", c), gseq[c], g_exp[c]);

        // Rotation after reset with all four requesting
        do_reset();
        run_rr(4'b1111, 15);
        r_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) check($sformatf("rot_grant%0d", i), gseq[1 + 3 * i], r_exp[i]);

        // Watchdog: slave never answers (dut T=16, dut8 T=8)
        do_reset();
        @(negedge clk);
        m_cyc_i = 4'b0010; m_stb_i = 4'b0010;
        for (int c = 1; c <= 22; c++) begin
            @(negedge clk);
            if (c == 21) idle_inputs();
            #1;
            check($sformatf("wd16_err_c%0d", c), {m_err_o, timeout_o}, (c == 17) ? 5'b00101 : 5'b0);
            check($sformatf("wd16_scyc_c%0d", c), {s_cyc_o, s_stb_o}, (c < 17) ? 2'b11 : 2'b00);
            check($sformatf("wd8_err_c%0d", c), {m_err_8, timeout_8}, (c == 9) ? 5'b00101 : 5'b0);
            check($sformatf("wd_busy_c%0d", c), {busy_o, busy_8}, (c <= 21) ? 2'b11 : 2'b00);
        end

        // Ack in the expiry cycle (dut8, T=8)
        do_reset();
        @(negedge clk);
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            s_ack_i = (c == 8);
            #1;
            check($sformatf("ackexp_noerr_c%0d", c), {m_err_8, timeout_8, m_err_o, timeout_o}, '0);
            if (c == 8) check("ackexp_ack", m_ack_8, 4'b0100);
            if (c >= 9) check($sformatf("ackexp_owned_c%0d", c), {busy_8, s_cyc_8, gnt_8}, 6'b110100);
        end
        @(negedge clk);
        idle_inputs();

        // Asynchronous reset mid-transfer
        do_reset();
        @(negedge clk);
        m_cyc_i = 4'b0001; m_stb_i = 4'b0001;
        @(negedge clk); #1;
        check("midrst_owned", gnt_o, 4'b0001);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_async_drop", {gnt_o, s_cyc_o, s_stb_o, busy_o}, '0);
        @(negedge clk);
        rst = 1'b1;
        m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
        #1;
        check("midrst_idle_after", {busy_o, gnt_o}, '0);
        @(negedge clk); #1;
        check("midrst_m3_gnt", {gnt_o, s_cyc_o}, 5'b10001);

        // Table-driven pass-through with master 2 owning the bus
        do_reset();
        @(negedge clk);
        m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            m_cyc_i = tbl[i].cyc; m_stb_i = tbl[i].stb;
            s_ack_i = tbl[i].ack; s_err_i = tbl[i].err; s_dat_i = tbl[i].dat;
            #1;
            check($sformatf("tbl%0d", i),
                  {gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, m_dat_o},
                  {tbl[i].e_gnt, tbl[i].e_ack, tbl[i].e_err, tbl[i].e_scyc, tbl[i].e_sstb, tbl[i].dat});
        end

        // Randomized run against the reference model (dut, T=16)
        do_reset();
        mo_owner = -1; mo_ptr = N - 1; mo_stall = 0; mo_abort = 1'b0; mo_just = 1'b0;
        cyc_v = '0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            dead = ((c / 60) % 3 == 2);
            for (int k = 0; k < N; k++) begin
                if (cyc_v[k]) begin
                    if ($urandom_range(0, dead ? 24 : 5) == 0) cyc_v[k] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    cyc_v[k] = 1'b1;
                end
                stb_v[k] = cyc_v[k] & ($urandom_range(0, 3) != 0);
                m_we_i[k] = 1'(($urandom >> 3) & 1);
                m_adr_i[k * AW +: AW] = $urandom;
                m_dat_i[k * DW +: DW] = $urandom;
                m_sel_i[k * SW +: SW] = SW'($urandom);
            end
            m_cyc_i = cyc_v; m_stb_i = stb_v;
            s_ack_i = !dead && ($urandom_range(0, 2) == 0);
            s_err_i = !dead && ($urandom_range(0, 19) == 0);
            s_dat_i = $urandom;
            #1;
            // Expected outputs from the model
            e_gnt = '0; e_ack = '0; e_err = '0; e_scyc = 1'b0; e_sstb = 1'b0;
            e_tmo = 1'b0; e_busy = (mo_owner >= 0); e_adr = '0; e_we = 1'b0;
            if (mo_owner >= 0) begin
                e_gnt = N'(1) << mo_owner;
                e_adr = m_adr_i[mo_owner * AW +: AW];
                e_we  = m_we_i[PW'(mo_owner)];
                if (!mo_abort) begin
                    e_scyc = m_cyc_i[PW'(mo_owner)];
                    e_sstb = m_stb_i[PW'(mo_owner)];
                    if (s_ack_i) e_ack = e_gnt;
                    if (s_err_i) e_err = e_gnt;
                end else if (mo_just) begin
                    e_err = e_gnt;
                    e_tmo = 1'b1;
                end
            end
            check($sformatf("rand_c%0d", c),
                  {gnt_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, timeout_o, busy_o, s_adr_o, s_we_o},
                  {e_gnt, e_ack, e_err, e_scyc, e_sstb, e_tmo, e_busy, e_adr, e_we});
            // Advance the model by one clock
            if (mo_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    int k;
                    k = (mo_ptr + i) % N;
                    if (mo_owner < 0 && m_cyc_i[PW'(k)]) begin
                        mo_owner = k; mo_ptr = k; mo_stall = 0;
                    end
                end
            end else if (!mo_abort) begin
                if (!m_cyc_i[PW'(mo_owner)]) mo_owner = -1;
                else if (s_ack_i || s_err_i) mo_stall = 0;
                else if (m_stb_i[PW'(mo_owner)]) begin
                    mo_stall++;
                    if (mo_stall == T16) begin
                        mo_abort = 1'b1; mo_just = 1'b1;
                    end
                end
            end else begin
                mo_just = 1'b0;
                if (!m_cyc_i[PW'(mo_owner)]) begin
                    mo_owner = -1; mo_abort = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
